// File: rtl/regfile_write_arbiter_pkg.sv
// Shared sizing for the register-file write arbiter slice.
package regfile_write_arbiter_pkg;

    localparam int DEF_NUM_REQ       = 3;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_DATA_WIDTH    = 32;

    // Width of an index into a requester vector; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant selection: the search begins just after the previous
// winner and wraps, so every requester is reached within N cycles.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             enable,
    output logic [N-1:0]     grant
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk the requesters starting at last_grant+1 and take the first valid one.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % N);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates several write requesters onto a single register-file write
// port: one grant per cycle, round-robin, with a registered write stage and
// a scoreboard-style mask of registers that have a write in flight.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDRESS_WIDTH-1:0]      write_addr,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          regwrite_en,
    output logic [2**ADDRESS_WIDTH-1:0]   pending_mask
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         grant_idx;
    logic [NUM_REQ-1:0]       grant;
    logic                     grant_any;
    logic                     arb_en;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [ADDRESS_WIDTH-1:0] pm_addr;

    // Reset is gated in combinationally so no handshake completes while it is held.
    assign arb_en = !hold && !rst;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign grant_any = |grant;

    // Convert the one-hot grant into an index and mux out the winner's payload.
    always_comb begin
        grant_idx = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
                sel_addr  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Remember the last winner; idle and held cycles keep the rotation point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (grant_any) begin
            last_grant <= grant_idx;
        end
    end

    // Write stage: register the granted write; register 0 is consumed silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_addr  <= '0;
            write_data  <= '0;
            regwrite_en <= 1'b0;
        end else if (grant_any) begin
            write_addr  <= sel_addr;
            write_data  <= sel_data;
            regwrite_en <= |sel_addr;
        end else begin
            regwrite_en <= 1'b0;
        end
    end

    // Registers with a write still waiting at a requester or sitting in the write stage.
    always_comb begin
        pending_mask = '0;
        pm_addr      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pm_addr = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            if (req_valid[i] && !grant[i] && (pm_addr != '0)) begin
                pending_mask[pm_addr] = 1'b1;
            end
        end
        if (regwrite_en) begin
            pending_mask[write_addr] = 1'b1;
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NUM_REQ SHALL default to 3 and set the number of write requesters.
REQ-002 Parameter ADDRESS_WIDTH SHALL default to 5 and set the register address width.
REQ-003 Parameter DATA_WIDTH SHALL default to 32 and set the register data width.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 hold  input  1  pipeline stall; while high no request is granted.
REQ-007 req_valid  input  NUM_REQ  per-requester write request.
REQ-008 req_addr  input  NUM_REQ*ADDRESS_WIDTH  packed destination addresses, requester i at slice i.
REQ-009 req_data  input  NUM_REQ*DATA_WIDTH  packed write data, requester i at slice i.
REQ-010 req_ready  output  NUM_REQ  one-hot-or-zero grant; transfer when req_valid[i] && req_ready[i].
REQ-011 write_addr  output  ADDRESS_WIDTH  register-file write address, registered.
REQ-012 write_data  output  DATA_WIDTH  register-file write data, registered.
REQ-013 regwrite_en  output  1  register-file write enable, registered.
REQ-014 pending_mask  output  2**ADDRESS_WIDTH  bit r high when a write to register r is waiting or staged.

Function
REQ-015 req_ready SHALL be combinational: at most one bit high, only for a requester with req_valid high, all zero while hold or rst is high.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, wrapping; first valid requester wins.
REQ-017 last_grant SHALL update only in a cycle with a grant; idle or held cycles leave it unchanged.
REQ-018 A granted request SHALL appear on write_addr/write_data with regwrite_en high on the following cycle (latency 1).
REQ-019 regwrite_en SHALL be high for exactly one cycle per grant; with no grant in a cycle, regwrite_en SHALL be low next cycle and write_addr/write_data SHALL hold their values.
REQ-020 A granted request with address 0 SHALL be consumed (ready asserted) but SHALL produce regwrite_en low.
REQ-021 Back-to-back grants on consecutive cycles SHALL be supported, giving one write per cycle sustained.
REQ-022 pending_mask SHALL be the OR of decoded req_addr over all valid, non-granted requesters plus write_addr when regwrite_en is high; address 0 SHALL never set a bit.
REQ-023 Two requesters targeting the same address SHALL be serviced in round-robin order; the later grant's data wins in the register file.
REQ-024 A requester SHALL be granted within NUM_REQ cycles of asserting req_valid, absent hold.
REQ-025 Requester inputs changing while not granted SHALL have no effect on state.

Reset
REQ-026 While rst is high: regwrite_en=0, write_addr=0, write_data=0, req_ready=0, and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-027 Assertion of rst mid-operation SHALL immediately clear regwrite_en; a staged write is discarded, and requests not yet granted stay pending at the requester.
REQ-028 pending_mask SHALL reflect only valid inputs during and after reset.

Structure
REQ-029 A shared package SHALL hold ADDRESS_WIDTH, DATA_WIDTH and the NUM_REQ default.
REQ-030 The round-robin grant logic SHALL be one sub-module, rr_arbiter, with inputs request vector, last_grant, enable and a one-hot grant output.

Verification
REQ-031 Reset release, req_valid=3'b111, addrs 1/2/3 -> writes to 1,2,3 on cycles 1,2,3 after the first grant, in that order.
REQ-032 Only req 1 valid for 4 cycles, addr 5, data 0xA5A5A5A5 -> four regwrite_en pulses, write_addr=5, last_grant=1 throughout.
REQ-033 req 0, addr 0, data 0xFFFFFFFF -> req_ready[0] pulses, regwrite_en stays 0, pending_mask stays 0.
REQ-034 hold=1 for 3 cycles with req 2 valid, addr 7 -> req_ready=0, regwrite_en=0, pending_mask[7]=1; grant on the first cycle after hold drops.
REQ-035 reqs 0 and 2 valid, both addr 4, data 0x11/0x22 -> two writes in round-robin order, and the final register 4 value is the later grant's data.
REQ-036 rst asserted the cycle after a grant -> regwrite_en=0 within the same cycle and no write occurs; after release, arbitration restarts at requester 0.
